fetch_queue_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions in a small FIFO and presents them with their PC+4 to IF/ID under a valid/ready handshake; `id_ready` is driven from the inverse of the hazard-unit stall.
- A redirect (taken branch, jump, jr) flushes the queue and discards responses already in flight.

---
 rtl/fetch_queue_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - fetch PC, credit-limited imem requests and IF/ID queue; optional perf counters under FETCH_PERF_CNT_EN
module fetch_queue_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] fetch_pc
);
    localparam int unsigned     PW      = $clog2(DEPTH);
    localparam int unsigned     CW      = PW + 1;
    localparam logic [CW-1:0]   L_FULL  = CW'(DEPTH);
    localparam logic [CW:0]     L_LIMIT = (CW + 1)'(DEPTH);

    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc4   [DEPTH];

    logic [CW:0]   w_used;
    logic          w_credit_ok;
    logic          w_req_fire;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redirect_pc;

    // Queued entries plus requests in flight may never exceed the queue size,
    // so every response always has a slot waiting for it.
    assign w_used        = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit_ok   = w_used < L_LIMIT;
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req_valid = reset & w_credit_ok & ~redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // A response is discarded when it belongs to a flushed fetch stream,
    // including one arriving in the redirect cycle itself.
    assign w_drop = imem_resp_valid & (redirect_valid | (r_drop_cnt != '0));
    assign w_push = imem_resp_valid & ~w_drop;
    assign w_pop  = id_valid & id_ready & ~redirect_valid;

    assign id_valid = (r_count != '0);
    assign id_instr = r_instr[r_rd_ptr];
    assign id_pc4   = r_pc4[r_rd_ptr];
    assign fetch_pc = r_fetch_pc;

    // Fetch/response PCs, in-flight count and number of stale responses to discard
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_drop_cnt <= r_outstanding - CW'(imem_resp_valid);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
            end
        end
    end

    // Circular instruction queue; a redirect empties it and ignores any pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_instr[i] <= '0;
                r_pc4[i]   <= '0;
            end
        end else if (redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= imem_resp_data;
                r_pc4[r_wr_ptr]   <= r_resp_pc + 32'd4;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            assert (!(w_push && !w_pop && (r_count == L_FULL)));
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_stall;

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
    assign perf_stall   = r_perf_stall;

    // Saturating event counters for pushes, discarded responses and IF/ID stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_drop && (r_perf_dropped != 32'hFFFF_FFFF)) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
            if (id_valid && !id_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_ready;
    logic        id_ready;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [31:0] fetch_pc;

    logic        req_valid2;
    logic [31:0] req_addr2;
    logic        resp_valid2 = 1'b0;
    logic [31:0] resp_data2  = 32'h0;
    logic        id_valid2;
    logic [31:0] id_instr2;
    logic [31:0] id_pc4_2;
    logic [31:0] fetch_pc2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_dropped, perf_stall;
    logic [31:0] perf_fetched2, perf_dropped2, perf_stall2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc4(id_pc4),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_dropped(perf_dropped), .perf_stall(perf_stall),
`endif
        .fetch_pc(fetch_pc)
    );

    fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_req_addr(req_addr2),
        .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
        .id_valid(id_valid2), .id_ready(id_ready), .id_instr(id_instr2), .id_pc4(id_pc4_2),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched2), .perf_dropped(perf_dropped2), .perf_stall(perf_stall2),
`endif
        .fetch_pc(fetch_pc2)
    );

    // Memory models: in-order, returns the request address as data after lat cycles
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_log[$];
    logic [31:0] req_log2[$];
    logic        fire2 = 1'b0;
    logic [31:0] addr2 = 32'h0;

    always begin
        @(posedge clk);
        if (!reset) begin
            pend_addr.delete();
            pend_due.delete();
            fire2 = 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                req_log.push_back(imem_req_addr);
            end
            fire2 = req_valid2;
            addr2 = req_addr2;
            if (fire2) req_log2.push_back(addr2);
        end
        #1;
        cyc++;
        if (reset && (pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_addr.pop_front();
            void'(pend_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        resp_valid2 = fire2;
        resp_data2  = fire2 ? addr2 : 32'h0;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%0h exp=0", imem_req_valid); end
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got=%0h exp=0", id_valid); end
        n_tests++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr got=%0h exp=0", id_instr); end
        n_tests++; if (id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc4 got=%0h exp=0", id_pc4); end
        n_tests++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_pc got=%0h exp=0", fetch_pc); end
        n_tests++; if (fetch_pc2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_fetch_pc_wrap got=%0h exp=fffffff8", fetch_pc2); end
        n_tests++; if (req_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid_wrap got=%0h exp=0", req_valid2); end
`ifdef FETCH_PERF_CNT_EN
        n_tests++; if (perf_fetched !== 32'h0) begin n_fail++; $display("FAIL reset_perf_fetched got=%0h exp=0", perf_fetched); end
        n_tests++; if (perf_dropped !== 32'h0) begin n_fail++; $display("FAIL reset_perf_dropped got=%0h exp=0", perf_dropped); end
        n_tests++; if (perf_stall !== 32'h0) begin n_fail++; $display("FAIL reset_perf_stall got=%0h exp=0", perf_stall); end
`endif
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1; id_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_gap got=%0h exp=0", id_valid); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%0h exp=1", k, id_valid); end
            n_tests++; if (id_instr !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_instr[%0d] got=%0h exp=%0h", k, id_instr, 4 * k); end
            n_tests++; if (id_pc4 !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL stream_pc4[%0d] got=%0h exp=%0h", k, id_pc4, 4 * k + 4); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat = 1; id_ready = 1'b0;
        reset = 1'b1;
        req_log.delete();
        repeat (10) @(negedge clk);
        n_tests++; if (req_log.size() != 4) begin n_fail++; $display("FAIL bp_req_count got=%0d exp=4", req_log.size()); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid got=%0h exp=0", imem_req_valid); end
        n_tests++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got=%0h exp=1", id_valid); end
        n_tests++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL bp_hold_instr got=%0h exp=0", id_instr); end
        n_tests++; if (id_pc4 !== 32'h4) begin n_fail++; $display("FAIL bp_hold_pc4 got=%0h exp=4", id_pc4); end
`ifdef FETCH_PERF_CNT_EN
        n_tests++; if (perf_fetched !== 32'd4) begin n_fail++; $display("FAIL bp_perf_fetched got=%0d exp=4", perf_fetched); end
        n_tests++; if (perf_stall !== 32'd8) begin n_fail++; $display("FAIL bp_perf_stall got=%0d exp=8", perf_stall); end
`endif
        id_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_tests++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rel_valid[%0d] got=%0h exp=1", k, id_valid); end
            n_tests++; if (id_instr !== 32'(4 * k)) begin n_fail++; $display("FAIL bp_rel_instr[%0d] got=%0h exp=%0h", k, id_instr, 4 * k); end
            n_tests++; if (id_pc4 !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL bp_rel_pc4[%0d] got=%0h exp=%0h", k, id_pc4, 4 * k + 4); end
        end
    endtask

    task automatic test_redirect_latency();
        bit found;
        do_reset();
        lat = 3; id_ready = 1'b1;
        reset = 1'b1;
        req_log.delete();
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdl_req_in_redirect got=%0h exp=0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_tests++; if (req_log.size() != 2) begin n_fail++; $display("FAIL rdl_outstanding got=%0d exp=2", req_log.size()); end
        n_tests++; if (fetch_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL rdl_fetch_pc got=%0h exp=100", fetch_pc); end
        n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rdl_req_valid got=%0h exp=1", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rdl_req_addr got=%0h exp=100", imem_req_addr); end
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (id_valid === 1'b1) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rdl_timeout id_valid got=0 exp=1"); end
        else begin
            n_tests++; if (id_instr !== 32'h0000_0100) begin n_fail++; $display("FAIL rdl_first_instr got=%0h exp=100", id_instr); end
            n_tests++; if (id_pc4 !== 32'h0000_0104) begin n_fail++; $display("FAIL rdl_first_pc4 got=%0h exp=104", id_pc4); end
        end
`ifdef FETCH_PERF_CNT_EN
        n_tests++; if (perf_dropped !== 32'd2) begin n_fail++; $display("FAIL rdl_perf_dropped got=%0d exp=2", perf_dropped); end
`endif
        lat = 1;
    endtask

    task automatic test_redirect_collide();
        bit found;
        int n0;
        do_reset();
        lat = 1; id_ready = 1'b1;
        reset = 1'b1;
        req_log.delete();
        repeat (4) @(negedge clk);
        n_tests++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rdc_pre_valid got=%0h exp=1", id_valid); end
        n_tests++; if (imem_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rdc_pre_resp got=%0h exp=1", imem_resp_valid); end
        n0 = req_log.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdc_req_in_redirect got=%0h exp=0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rdc_queue_empty got=%0h exp=0", id_valid); end
        n_tests++; if (req_log.size() != n0) begin n_fail++; $display("FAIL rdc_no_issue got=%0d exp=%0d", req_log.size(), n0); end
        n_tests++; if (imem_req_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL rdc_req_addr got=%0h exp=200", imem_req_addr); end
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (id_valid === 1'b1) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rdc_timeout id_valid got=0 exp=1"); end
        else begin
            n_tests++; if (id_instr !== 32'h0000_0200) begin n_fail++; $display("FAIL rdc_first_instr got=%0h exp=200", id_instr); end
            n_tests++; if (id_pc4 !== 32'h0000_0204) begin n_fail++; $display("FAIL rdc_first_pc4 got=%0h exp=204", id_pc4); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [3];
        exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        do_reset();
        id_ready = 1'b1;
        reset = 1'b1;
        req_log2.delete();
        @(negedge clk);
        n_tests++; if (id_valid2 !== 1'b0) begin n_fail++; $display("FAIL wrap_first_gap got=%0h exp=0", id_valid2); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++; if (id_instr2 !== exp_addr[k]) begin n_fail++; $display("FAIL wrap_instr[%0d] got=%0h exp=%0h", k, id_instr2, exp_addr[k]); end
            n_tests++; if (id_pc4_2 !== exp_addr[k] + 32'd4) begin n_fail++; $display("FAIL wrap_pc4[%0d] got=%0h exp=%0h", k, id_pc4_2, exp_addr[k] + 32'd4); end
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (req_log2[k] !== exp_addr[k]) begin n_fail++; $display("FAIL wrap_req_addr[%0d] got=%0h exp=%0h", k, req_log2[k], exp_addr[k]); end
        end
    endtask

    task automatic test_reset_midop();
        bit found;
        do_reset();
        lat = 1; id_ready = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++; if (fetch_pc !== 32'h10) begin n_fail++; $display("FAIL mid_pre_fetch_pc got=%0h exp=10", fetch_pc); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_pre_req_valid got=%0h exp=0", imem_req_valid); end
        reset = 1'b0;
        #1;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid got=%0h exp=0", imem_req_valid); end
        n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_id_valid got=%0h exp=0", id_valid); end
        n_tests++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL mid_id_instr got=%0h exp=0", id_instr); end
        n_tests++; if (id_pc4 !== 32'h0) begin n_fail++; $display("FAIL mid_id_pc4 got=%0h exp=0", id_pc4); end
        n_tests++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL mid_fetch_pc got=%0h exp=0", fetch_pc); end
`ifdef FETCH_PERF_CNT_EN
        n_tests++; if (perf_fetched !== 32'h0) begin n_fail++; $display("FAIL mid_perf_fetched got=%0h exp=0", perf_fetched); end
        n_tests++; if (perf_dropped !== 32'h0) begin n_fail++; $display("FAIL mid_perf_dropped got=%0h exp=0", perf_dropped); end
        n_tests++; if (perf_stall !== 32'h0) begin n_fail++; $display("FAIL mid_perf_stall got=%0h exp=0", perf_stall); end
`endif
        @(negedge clk);
        reset = 1'b1;
        id_ready = 1'b1;
        #1;
        n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_resume_valid got=%0h exp=1", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL mid_resume_addr got=%0h exp=0", imem_req_addr); end
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (id_valid === 1'b1) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL mid_timeout id_valid got=0 exp=1"); end
        else begin
            n_tests++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL mid_first_instr got=%0h exp=0", id_instr); end
            n_tests++; if (id_pc4 !== 32'h4) begin n_fail++; $display("FAIL mid_first_pc4 got=%0h exp=4", id_pc4); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_req_ready = 1'b1;
        id_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_collide();
        test_wrap();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
